// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the nRISC ALU: datapath width, opcode width and
//   the ALUcontrol opcode values. The control unit imports this package too,
//   so opcode values must only ever change here.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W   = 8;  // datapath width
  localparam int ALU_OPW = 3;  // ALUcontrol width
  localparam int ALU_SHW = 3;  // shamt width (0..7)

  localparam logic [ALU_OPW-1:0] ALU_ADD = 3'h0;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 3'h1;
  localparam logic [ALU_OPW-1:0] ALU_AND = 3'h2;
  localparam logic [ALU_OPW-1:0] ALU_OR  = 3'h3;
  localparam logic [ALU_OPW-1:0] ALU_SLT = 3'h4;
  localparam logic [ALU_OPW-1:0] ALU_SLL = 3'h5;
  localparam logic [ALU_OPW-1:0] ALU_SRL = 3'h6;
  localparam logic [ALU_OPW-1:0] ALU_NOR = 3'h7;

endpackage

// File: rtl/alu_shifter.sv
// ---------------------------------------------------------------------------
// alu_shifter
//   Logical shifter for SLL / SRL. Both directions zero-fill; shamt == 0
//   passes a through unchanged.
// Ports
//   a      in  ALU_W    value to shift
//   shamt  in  ALU_SHW  shift amount, 0..7
//   dir    in  1        0 = shift left, 1 = shift right (logical)
//   result out ALU_W    shifted value
// ---------------------------------------------------------------------------
module alu_shifter
  import alu_pkg::*;
(
  input  logic [ALU_W-1:0]   a,
  input  logic [ALU_SHW-1:0] shamt,
  input  logic               dir,
  output logic [ALU_W-1:0]   result
);

  always_comb begin
    result = '0;
    if (dir) result = a >> shamt;
    else     result = a << shamt;
  end

endmodule

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   8-bit integer ALU of the nRISC datapath (register-file read ports ->
//   writeback mux). Eight operations selected by ALUcontrol; zero feeds the
//   branch logic.
// Ports (fixed positional order)
//   ALUcontrol in  3  operation select (see alu_pkg)
//   a          in  8  operand A, also the shifted value for SLL/SRL
//   b          in  8  operand B (ignored by the shifts)
//   ALUout     out 8  result
//   zero       out 1  1 when ALUout == 8'h00
//   shamt      in  3  shift amount
//   clock      in  1  rising-edge clock, only used with ALU_OUTREG_EN
//   reset      in  1  synchronous active-high reset, only used with
//                     ALU_OUTREG_EN
// Configuration
//   ALU_OUTREG_EN undefined: ALUout/zero are combinational (0-cycle).
//   ALU_OUTREG_EN defined  : ALUout is registered (1-cycle latency); reset
//                            at an edge forces ALUout = 0 (zero = 1).
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  logic [ALU_OPW-1:0] ALUcontrol,
  input  logic [ALU_W-1:0]   a,
  input  logic [ALU_W-1:0]   b,
  output logic [ALU_W-1:0]   ALUout,
  output logic               zero,
  input  logic [ALU_SHW-1:0] shamt,
  input  logic               clock,
  input  logic               reset
);

  logic [ALU_W-1:0] shift_res;
  logic [ALU_W-1:0] result;
  logic             shift_right;

  assign shift_right = (ALUcontrol == ALU_SRL);

  alu_shifter u_shifter (
    .a      (a),
    .shamt  (shamt),
    .dir    (shift_right),
    .result (shift_res)
  );

  // Unknown opcodes fall into the default arm and yield 8'h00.
  always_comb begin
    result = '0;
    case (ALUcontrol)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(ALU_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = shift_res;
      ALU_SRL: result = shift_res;
      ALU_NOR: result = ~(a | b);
      default: result = '0;
    endcase
  end

`ifdef ALU_OUTREG_EN
  // Reset takes priority over the result being captured at the same edge.
  always_ff @(posedge clock) begin
    if (reset) ALUout <= '0;
    else       ALUout <= result;
  end
`else
  assign ALUout = result;

  // clock and reset are intentionally unused in the combinational build.
  logic unused_clk_rst;
  assign unused_clk_rst = clock ^ reset;
`endif

  // zero always follows the final ALUout value, registered or not.
  assign zero = (ALUout == '0);

endmodule

// File: tb/tb_alu.sv
// ---------------------------------------------------------------------------
// tb_alu
//   Self-checking bench for alu. Directed vectors plus randomized vectors
//   against an arithmetic reference model. The registered-output section is
//   compiled only when ALU_OUTREG_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu;

  logic [2:0] ALUcontrol;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] ALUout;
  logic       zero;
  logic [2:0] shamt;
  logic       clock;
  logic       reset;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  alu dut (
    .ALUcontrol (ALUcontrol),
    .a          (a),
    .b          (b),
    .ALUout     (ALUout),
    .zero       (zero),
    .shamt      (shamt),
    .clock      (clock),
    .reset      (reset)
  );

  // ---------------- clock / reset ----------------
  logic clk_en = 1'b1;
  initial clock = 1'b0;
  always begin
    #5;
    if (clk_en) clock = ~clock;
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] model(input int op, input int ua,
                                       input int ub, input int sh);
    int sa, sb, r;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    case (op)
      0: r = (ua + ub) % 256;
      1: r = (ua - ub + 256) % 256;
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = (sa < sb) ? 1 : 0;
      5: r = (ua * (1 << sh)) % 256;
      6: r = ua / (1 << sh);
      7: r = 255 - (ua | ub);
      default: r = 0;
    endcase
    return r[7:0];
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [2:0] op, input logic [7:0] va,
                       input logic [7:0] vb, input logic [2:0] sh);
    ALUcontrol = op;
    a          = va;
    b          = vb;
    shamt      = sh;
  endtask

  task automatic comb_check(input string tag, input logic [2:0] op,
                            input logic [7:0] va, input logic [7:0] vb,
                            input logic [2:0] sh, input logic [7:0] exp,
                            input logic exp_z);
    drive(op, va, vb, sh);
    #1;
    check({tag, "_out"}, ALUout, exp);
    check({tag, "_zero"}, {7'b0, zero}, {7'b0, exp_z});
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] sweep_exp [8];
  logic [7:0] e;
  logic [2:0] rop;
  logic [7:0] ra, rb;
  logic [2:0] rsh;

  initial begin
    drive(3'h0, 8'h00, 8'h00, 3'h0);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

`ifndef ALU_OUTREG_EN
    // Sweep with the clock frozen high.
    clk_en = 1'b0;
    #2;
    clock = 1'b1;
    sweep_exp[0] = 8'h04; sweep_exp[1] = 8'h00;
    sweep_exp[2] = 8'h02; sweep_exp[3] = 8'h02;
    sweep_exp[4] = 8'h00; sweep_exp[5] = 8'h04;
    sweep_exp[6] = 8'h01; sweep_exp[7] = 8'hFD;
    for (int i = 0; i < 8; i++)
      comb_check($sformatf("sweep_op%0d", i), 3'(i), 8'h02, 8'h02, 3'd1,
                 sweep_exp[i], sweep_exp[i] == 8'h00);

    // Wrap-around limits.
    comb_check("add_wrap", 3'h0, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1);
    comb_check("sub_wrap", 3'h1, 8'h00, 8'h01, 3'd0, 8'hFF, 1'b0);

    // Signed compare.
    comb_check("slt_neg_pos", 3'h4, 8'h80, 8'h01, 3'd0, 8'h01, 1'b0);
    comb_check("slt_pos_neg", 3'h4, 8'h01, 8'h80, 3'd0, 8'h00, 1'b1);
    comb_check("slt_equal",   3'h4, 8'h7F, 8'h7F, 3'd0, 8'h00, 1'b1);

    // Shift limits; b must be ignored.
    comb_check("sll_7",  3'h5, 8'h81, 8'h5A, 3'd7, 8'h80, 1'b0);
    comb_check("srl_7",  3'h6, 8'h81, 8'hA5, 3'd7, 8'h01, 1'b0);
    comb_check("sll_0",  3'h5, 8'h81, 8'hFF, 3'd0, 8'h81, 1'b0);
    comb_check("srl_0",  3'h6, 8'h81, 8'h00, 3'd0, 8'h81, 1'b0);

    // Clock and reset have no effect in this build.
    clk_en = 1'b1;
    reset  = 1'b1;
    comb_check("rst_ignored", 3'h0, 8'h10, 8'h22, 3'd0, 8'h32, 1'b0);
    @(posedge clock);
    #1;
    check("rst_ignored_edge", ALUout, 8'h32);
    reset = 1'b0;

    // Randomized against the model.
    for (int i = 0; i < 300; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rsh = 3'($urandom_range(0, 7));
      e   = model(int'(rop), int'(ra), int'(rb), int'(rsh));
      comb_check($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, rsh, e,
                 e == 8'h00);
    end
`else
    // Reset state after the reset edges.
    check("reg_reset_out", ALUout, 8'h00);
    check("reg_reset_zero", {7'b0, zero}, 8'h01);

    // Output tracks the result sampled at the previous edge.
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      rop = (i < 8) ? 3'h0 : 3'($urandom_range(0, 7));
      ra  = 8'($urandom_range(0, 255));
      rb  = 8'($urandom_range(0, 255));
      rsh = 3'($urandom_range(0, 7));
      drive(rop, ra, rb, rsh);
      exp_q.push_back(model(int'(rop), int'(ra), int'(rb), int'(rsh)));
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check($sformatf("reg%0d_out", i), ALUout, e);
      check($sformatf("reg%0d_zero", i), {7'b0, zero}, {7'b0, e == 8'h00});
      // Outputs must hold while inputs move between edges.
      drive(3'h7, ~ra, ~rb, rsh);
      #1;
      check($sformatf("reg%0d_hold", i), ALUout, e);
    end

    // Reset for one edge discards the in-flight ADD.
    @(negedge clock);
    drive(3'h0, 8'h12, 8'h34, 3'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("reg_midrst_out", ALUout, 8'h00);
    check("reg_midrst_zero", {7'b0, zero}, 8'h01);
    @(negedge clock);
    reset = 1'b0;
    drive(3'h0, 8'h20, 8'h03, 3'd0);
    @(posedge clock);
    #1;
    check("reg_resume_out", ALUout, 8'h23);
    check("reg_resume_zero", {7'b0, zero}, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
